bmp_copy_engine: RTL

//  Parametrised ROM-to-RAM byte mover for image buffers; replaces the fixed-size alternating read/write loader.

---
 rtl/bmp_copy_if.sv | 34 +++
 rtl/bmp_copy_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bmp_copy_if.sv
// Command, ROM-read and RAM-write signal bundle between the test sequencer/memories and bmp_copy_engine.
// master drives commands and ROM read data; slave is the copy engine.
interface bmp_copy_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 21
);
    logic                  start;
    logic                  abort;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [ADDR_WIDTH-1:0] dst_base;
    logic [LEN_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] fill_val;
    logic [DATA_WIDTH-1:0] ROM_out;
    logic                  ROM_ren;
    logic [ADDR_WIDTH-1:0] ROM_addr;
    logic                  RAM_ren;
    logic                  RAM_wen;
    logic [ADDR_WIDTH-1:0] RAM_addr;
    logic [DATA_WIDTH-1:0] RAM_in;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, mode, src_base, dst_base, len, fill_val, ROM_out,
        input  ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_addr, RAM_in, busy, done
    );

    modport slave (
        input  start, abort, mode, src_base, dst_base, len, fill_val, ROM_out,
        output ROM_ren, ROM_addr, RAM_ren, RAM_wen, RAM_addr, RAM_in, busy, done
    );
endinterface

// File: rtl/bmp_copy_engine.sv
// Streams len words from a ROM base to a RAM base at one word per cycle,
// with copy / invert / constant-fill modes and abort.
module bmp_copy_engine #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 21
) (
    input logic       clk,
    input logic       rst,
    bmp_copy_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_FILL = 2'd2;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] src_q, src_n;
    logic [ADDR_WIDTH-1:0] dst_q, dst_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n;
    logic [1:0]            mode_q, mode_n;
    logic [DATA_WIDTH-1:0] fill_q, fill_n;
    logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_n;
    logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_n;
    logic                  wr_pend_q, wr_pend_n;
    logic                  rom_ren_q, rom_ren_n;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_n;
    logic                  ram_wen_q, ram_wen_n;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_n;
    logic [DATA_WIDTH-1:0] ram_in_q, ram_in_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            fill_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            wr_pend_q  <= 1'b0;
            rom_ren_q  <= 1'b0;
            rom_addr_q <= '0;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            src_q      <= src_n;
            dst_q      <= dst_n;
            len_q      <= len_n;
            mode_q     <= mode_n;
            fill_q     <= fill_n;
            rd_cnt_q   <= rd_cnt_n;
            wr_cnt_q   <= wr_cnt_n;
            wr_pend_q  <= wr_pend_n;
            rom_ren_q  <= rom_ren_n;
            rom_addr_q <= rom_addr_n;
            ram_wen_q  <= ram_wen_n;
            ram_addr_q <= ram_addr_n;
            ram_in_q   <= ram_in_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    // Next-state, read issue and one-cycle-delayed write pipeline
    always_comb begin
        state_n    = state_q;
        src_n      = src_q;
        dst_n      = dst_q;
        len_n      = len_q;
        mode_n     = mode_q;
        fill_n     = fill_q;
        rd_cnt_n   = rd_cnt_q;
        wr_cnt_n   = wr_cnt_q;
        wr_pend_n  = 1'b0;
        rom_ren_n  = 1'b0;
        rom_addr_n = rom_addr_q;
        ram_wen_n  = 1'b0;
        ram_addr_n = ram_addr_q;
        ram_in_n   = ram_in_q;
        busy_n     = busy_q;
        done_n     = 1'b0;

        // ROM data for the read issued last cycle is on ROM_out now
        if (wr_pend_q) begin
            ram_wen_n  = 1'b1;
            ram_addr_n = dst_q + ADDR_WIDTH'(wr_cnt_q);
            wr_cnt_n   = wr_cnt_q + LEN_WIDTH'(1);
            case (mode_q)
                MODE_INV:  ram_in_n = ~bus.ROM_out;
                MODE_FILL: ram_in_n = fill_q;
                default:   ram_in_n = bus.ROM_out;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    src_n    = bus.src_base;
                    dst_n    = bus.dst_base;
                    len_n    = bus.len;
                    mode_n   = bus.mode;
                    fill_n   = bus.fill_val;
                    rd_cnt_n = '0;
                    wr_cnt_n = '0;
                    busy_n   = 1'b1;
                    // Empty transfer still passes DRAIN so done lands at T+2+len
                    state_n  = (bus.len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                rom_ren_n  = (mode_q != MODE_FILL);
                rom_addr_n = src_q + ADDR_WIDTH'(rd_cnt_q);
                rd_cnt_n   = rd_cnt_q + LEN_WIDTH'(1);
                wr_pend_n  = 1'b1;
                if (rd_cnt_q == len_q - LEN_WIDTH'(1)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                state_n = FIN;
            end
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort drops any in-flight write and freezes the address outputs
        if (bus.abort) begin
            state_n    = IDLE;
            wr_pend_n  = 1'b0;
            rom_ren_n  = 1'b0;
            rom_addr_n = rom_addr_q;
            ram_wen_n  = 1'b0;
            ram_addr_n = ram_addr_q;
            ram_in_n   = ram_in_q;
            busy_n     = 1'b0;
            done_n     = 1'b0;
        end
    end

    assign bus.ROM_ren  = rom_ren_q;
    assign bus.ROM_addr = rom_addr_q;
    assign bus.RAM_ren  = 1'b0;
    assign bus.RAM_wen  = ram_wen_q;
    assign bus.RAM_addr = ram_addr_q;
    assign bus.RAM_in   = ram_in_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
